// File: rtl/ca_corr_accum_pkg.sv
// -----------------------------------------------------------------------------
// ca_corr_accum_pkg
// Shared definitions for the C/A integrate-and-dump correlator:
//   - state_t       : channel state encoding (IDLE / SYNC / ACCUM)
//   - ACC_W_DEF     : default accumulator width per arm (signal is {I, Q},
//                     I in the upper half, Q in the lower half)
//   - prod_neg()    : sign of a 1-bit x 1-bit product (1 means -1)
// -----------------------------------------------------------------------------
package ca_corr_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_ACCUM = 2'd2
    } state_t;

    localparam int ACC_W_DEF = 16;

    // Sign-bit encoding is 0 = +1, 1 = -1, so the product sign is the XOR.
    function automatic logic prod_neg(input logic a, input logic b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/ca_corr_accum_sat_accum.sv
// -----------------------------------------------------------------------------
// ca_corr_accum_sat_accum  (the sat_accum arm of the correlator)
// One signed saturating +/-1 accumulator.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_clr      : clear accumulator and sticky sat bit
//   i_load     : load +/-1 (first sample of a period), clears sat bit
//   i_add      : add +/-1 with saturation
//   i_neg      : step sign (0 = +1, 1 = -1)
//   o_acc      : accumulator value, two's complement
//   o_sat      : sticky saturation flag for the current period
// Priority: rst/i_clr > i_load > i_add.
// -----------------------------------------------------------------------------
module ca_corr_accum_sat_accum #(
    parameter int ACC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_load,
    input  logic                    i_add,
    input  logic                    i_neg,
    output logic signed [ACC_W-1:0] o_acc,
    output logic                    o_sat
);

    localparam logic signed [ACC_W-1:0] MAX_V   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ONE     = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] NEG_ONE = '1;

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_sat;
    logic                    w_clip;

    // Saturating +/-1 step: holds at the rail instead of wrapping.
    function automatic logic signed [ACC_W-1:0] sat_step(
        input logic signed [ACC_W-1:0] a,
        input logic                    neg
    );
        if (!neg)
            return (a == MAX_V) ? a : a + ONE;
        else
            return (a == MIN_V) ? a : a - ONE;
    endfunction

    assign w_clip = i_neg ? (r_acc == MIN_V) : (r_acc == MAX_V);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_load) begin
            r_acc <= i_neg ? NEG_ONE : ONE;
            r_sat <= 1'b0;
        end else if (i_add) begin
            r_acc <= sat_step(r_acc, i_neg);
            r_sat <= r_sat | w_clip;
        end
    end

    assign o_acc = r_acc;
    assign o_sat = r_sat;

endmodule

// File: rtl/ca_corr_accum.sv
// -----------------------------------------------------------------------------
// ca_corr_accum
// Integrate-and-dump correlator for one GPS tracking channel. Multiplies
// carrier-wiped 1-bit I/Q samples by the local C/A chip, accumulates over one
// code period and dumps {I, Q} with a one-cycle trigger.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   enable          : channel enable; low forces IDLE and clears the period
//   sample_valid    : qualifies i_sign, q_sign, ca_chip, code_epoch
//   i_sign, q_sign  : sample signs (0 = +1, 1 = -1)
//   ca_chip         : local chip (0 = +1, 1 = -1)
//   code_epoch      : sample is the first chip of a new code period
//   signal          : last dump {I_acc, Q_acc}
//   signal_trigger  : one-cycle pulse when signal updates
//   sat_flag        : either arm saturated during the dumped period
//   timeout         : sticky, set when a period runs MAX_SAMPLES without epoch
//   dump_count      : dumps since reset, wraps
// -----------------------------------------------------------------------------
module ca_corr_accum
    import ca_corr_accum_pkg::*;
#(
    parameter int ACC_W       = ACC_W_DEF,
    parameter int MAX_SAMPLES = 16383,
    parameter int CNT_W       = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 sample_valid,
    input  logic                 i_sign,
    input  logic                 q_sign,
    input  logic                 ca_chip,
    input  logic                 code_epoch,
    output logic [2*ACC_W-1:0]   signal,
    output logic                 signal_trigger,
    output logic                 sat_flag,
    output logic                 timeout,
    output logic [15:0]          dump_count
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_SAMPLES - 1);

    state_t                  r_state, w_state_next;
    logic [CNT_W-1:0]        r_cnt, w_cnt_next;
    logic [2*ACC_W-1:0]      r_signal;
    logic                    r_trigger, r_sat_flag, r_timeout;
    logic [15:0]             r_dump_count;

    logic                    w_clr, w_load, w_add, w_dump, w_to_set;
    logic                    w_pi_neg, w_pq_neg;
    logic signed [ACC_W-1:0] w_acc_i, w_acc_q;
    logic                    w_sat_i, w_sat_q;

    assign w_pi_neg = prod_neg(i_sign, ca_chip);
    assign w_pq_neg = prod_neg(q_sign, ca_chip);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_clr        = 1'b0;
        w_load       = 1'b0;
        w_add        = 1'b0;
        w_dump       = 1'b0;
        w_to_set     = 1'b0;
        if (!enable) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
            w_clr        = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: w_state_next = ST_SYNC;
                ST_SYNC: begin
                    // The first epoch only opens a period; it never dumps.
                    if (sample_valid && code_epoch) begin
                        w_state_next = ST_ACCUM;
                        w_load       = 1'b1;
                        w_cnt_next   = CNT_ONE;
                    end
                end
                ST_ACCUM: begin
                    if (sample_valid) begin
                        // Epoch wins over a coincident timeout.
                        if (code_epoch) begin
                            w_dump     = 1'b1;
                            w_load     = 1'b1;
                            w_cnt_next = CNT_ONE;
                        end else if (r_cnt == CNT_LAST) begin
                            w_to_set     = 1'b1;
                            w_clr        = 1'b1;
                            w_cnt_next   = '0;
                            w_state_next = ST_SYNC;
                        end else begin
                            w_add      = 1'b1;
                            w_cnt_next = r_cnt + CNT_ONE;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    ca_corr_accum_sat_accum #(.ACC_W(ACC_W)) u_acc_i (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_load (w_load),
        .i_add  (w_add),
        .i_neg  (w_pi_neg),
        .o_acc  (w_acc_i),
        .o_sat  (w_sat_i)
    );

    ca_corr_accum_sat_accum #(.ACC_W(ACC_W)) u_acc_q (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_load (w_load),
        .i_add  (w_add),
        .i_neg  (w_pq_neg),
        .o_acc  (w_acc_q),
        .o_sat  (w_sat_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_signal     <= '0;
            r_trigger    <= 1'b0;
            r_sat_flag   <= 1'b0;
            r_timeout    <= 1'b0;
            r_dump_count <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_trigger <= w_dump;
            // Accumulators still hold the pre-epoch totals on the dump cycle.
            if (w_dump) begin
                r_signal     <= {w_acc_i, w_acc_q};
                r_sat_flag   <= w_sat_i | w_sat_q;
                r_dump_count <= r_dump_count + 16'd1;
            end
            if (!enable)
                r_timeout <= 1'b0;
            else if (w_to_set)
                r_timeout <= 1'b1;
        end
    end

    assign signal         = r_signal;
    assign signal_trigger = r_trigger;
    assign sat_flag       = r_sat_flag;
    assign timeout        = r_timeout;
    assign dump_count     = r_dump_count;

endmodule

// File: tb/tb_ca_corr_accum.sv
module tb_ca_corr_accum;

    localparam int AW   = 8;
    localparam int MAXS = 300;
    localparam int VMAX = 127;
    localparam int VMIN = -128;

    logic        clk = 1'b0;
    logic        rst, enable, sample_valid, i_sign, q_sign, ca_chip, code_epoch;
    logic [15:0] signal;
    logic        signal_trigger, sat_flag, timeout;
    logic [15:0] dump_count;

    int checks = 0;
    int errors = 0;

    ca_corr_accum #(.ACC_W(AW), .MAX_SAMPLES(MAXS), .CNT_W(9)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .sample_valid   (sample_valid),
        .i_sign         (i_sign),
        .q_sign         (q_sign),
        .ca_chip        (ca_chip),
        .code_epoch     (code_epoch),
        .signal         (signal),
        .signal_trigger (signal_trigger),
        .sat_flag       (sat_flag),
        .timeout        (timeout),
        .dump_count     (dump_count)
    );

    always #5 clk = ~clk;

    // Reference model: the products of the open period are kept as a list
    // and summed with clamping only when the period is dumped.
    int          qi[$];
    int          qq[$];
    bit          m_armed, m_open;
    logic [15:0] e_sig, e_dc;
    bit          e_trig, e_sat, e_to;

    function automatic void fold(input bit arm, output int val, output bit sat);
        int a, nx, n;
        a = 0; sat = 0;
        n = arm ? qq.size() : qi.size();
        for (int k = 0; k < n; k++) begin
            nx = a + (arm ? qq[k] : qi[k]);
            if (nx > VMAX) begin a = VMAX; sat = 1; end
            else if (nx < VMIN) begin a = VMIN; sat = 1; end
            else a = nx;
        end
        val = a;
    endfunction

    task automatic model_edge();
        int pi, pq, vi, vq;
        bit si, sq;
        if (rst) begin
            m_armed = 0; m_open = 0; qi.delete(); qq.delete();
            e_sig = 0; e_dc = 0; e_trig = 0; e_sat = 0; e_to = 0;
        end else begin
            e_trig = 0;
            if (!enable) begin
                m_armed = 0; m_open = 0; qi.delete(); qq.delete(); e_to = 0;
            end else if (!m_armed) begin
                m_armed = 1;
            end else if (sample_valid) begin
                pi = (i_sign == ca_chip) ? 1 : -1;
                pq = (q_sign == ca_chip) ? 1 : -1;
                if (code_epoch) begin
                    if (m_open) begin
                        fold(0, vi, si);
                        fold(1, vq, sq);
                        e_sig  = {vi[7:0], vq[7:0]};
                        e_sat  = si | sq;
                        e_dc   = e_dc + 16'd1;
                        e_trig = 1;
                    end
                    qi.delete(); qq.delete();
                    qi.push_back(pi); qq.push_back(pq);
                    m_open = 1;
                end else if (m_open) begin
                    if (qi.size() + 1 == MAXS) begin
                        e_to = 1; m_open = 0; qi.delete(); qq.delete();
                    end else begin
                        qi.push_back(pi); qq.push_back(pq);
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit v, input bit is,
                        input bit qs, input bit ca, input bit ep);
        @(negedge clk);
        rst = r; enable = e; sample_valid = v;
        i_sign = is; q_sign = qs; ca_chip = ca; code_epoch = ep;
        @(posedge clk);
        model_edge();
        #1;
        chk("signal", 32'(signal), 32'(e_sig));
        chk("trigger", 32'(signal_trigger), 32'(e_trig));
        chk("sat_flag", 32'(sat_flag), 32'(e_sat));
        chk("timeout", 32'(timeout), 32'(e_to));
        chk("dump_count", 32'(dump_count), 32'(e_dc));
    endtask

    // Valid sample; pi/pq chosen as products (1 = +1), ca random.
    task automatic samp(input bit ep, input bit ip, input bit qp);
        bit ca;
        ca = 1'($urandom);
        step(0, 1, 1, ip ? ca : ~ca, qp ? ca : ~ca, ca, ep);
    endtask

    task automatic gap();
        step(0, 1, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r, e, v, ca, ep;

        // Reset
        step(1, 1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_signal", 32'(signal), 32'h0);
        chk("rst_count", 32'(dump_count), 32'h0);

        // Enable, first epoch, 99 samples: I all +1, Q alternating -> I=100, Q=0
        step(0, 1, 0, 0, 0, 0, 0);
        samp(1, 1, 1);
        for (int k = 0; k < 99; k++) samp(0, 1, (k % 2) == 1);
        chk("pre_dump_trig", 32'(signal_trigger), 32'h0);
        samp(1, 1, 0);
        chk("dump1_signal", 32'(signal), 32'h6400);
        chk("dump1_trig", 32'(signal_trigger), 32'h1);
        chk("dump1_sat", 32'(sat_flag), 32'h0);
        chk("dump1_count", 32'(dump_count), 32'h1);

        // Saturation: I +1 and Q -1 for 201 samples
        for (int k = 0; k < 200; k++) samp(0, 1, 0);
        chk("trig_one_cycle", 32'(signal_trigger), 32'h0);
        samp(1, 1, 1);
        chk("sat_signal", 32'(signal), 32'h7F80);
        chk("sat_flag", 32'(sat_flag), 32'h1);
        chk("sat_count", 32'(dump_count), 32'h2);

        // Timeout after MAXS-1 post-epoch samples, no dump
        for (int k = 0; k < 298; k++) samp(0, 1, 1);
        chk("to_before", 32'(timeout), 32'h0);
        samp(0, 1, 1);
        chk("to_set", 32'(timeout), 32'h1);
        chk("to_no_trig", 32'(signal_trigger), 32'h0);
        for (int k = 0; k < 3; k++) samp(0, 1, 1);
        samp(1, 1, 1);
        chk("to_epoch_nodump", 32'(signal_trigger), 32'h0);
        chk("to_count_hold", 32'(dump_count), 32'h2);
        for (int k = 0; k < 10; k++) samp(0, 1, 1);
        samp(1, 0, 0);
        chk("post_to_signal", 32'(signal), 32'h0B0B);
        chk("to_sticky", 32'(timeout), 32'h1);

        // One-cycle enable drop mid-period
        for (int k = 0; k < 5; k++) samp(0, 1, 1);
        step(0, 0, 1, 0, 0, 0, 1);
        chk("dis_timeout", 32'(timeout), 32'h0);
        chk("dis_signal", 32'(signal), 32'h0B0B);
        chk("dis_trig", 32'(signal_trigger), 32'h0);
        step(0, 1, 0, 0, 0, 0, 0);

        // Valid every third cycle; first epoch from SYNC does not dump
        samp(1, 1, 0);
        chk("sync_epoch_nodump", 32'(signal_trigger), 32'h0);
        for (int k = 0; k < 4; k++) begin gap(); gap(); samp(0, 1, 0); end
        gap(); gap();
        samp(1, 0, 0);
        chk("gap_trig", 32'(signal_trigger), 32'h1);
        chk("gap_signal", 32'(signal), 32'h05FB);
        gap();
        chk("gap_trig_low", 32'(signal_trigger), 32'h0);

        // Reset together with an epoch mid-period
        for (int k = 0; k < 4; k++) samp(0, 1, 1);
        step(1, 1, 1, 0, 0, 0, 1);
        chk("rst_epoch_trig", 32'(signal_trigger), 32'h0);
        chk("rst_epoch_signal", 32'(signal), 32'h0);
        chk("rst_epoch_count", 32'(dump_count), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            r  = ($urandom_range(999) == 0);
            e  = ($urandom_range(499) != 0);
            v  = ($urandom_range(9) < 6);
            ep = ($urandom_range(119) == 0);
            ca = 1'($urandom);
            step(r, e, v, ca ^ ($urandom_range(7) == 0), 1'($urandom), ca, ep);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
